ac_motor_pwm_gen: RTL and testbench

Three-phase, center-aligned PWM generator for the AC motor drive. Compares per-phase duty values against a shared up/down triangle carrier and produces one switching-command bit per phase. Each bit feeds the `S_IN` input of that phase's dead-time / switch-delay stage. Duty and period changes are double-buffered and applied only at a carrier turning point, so no output glitches mid-period.

---
 rtl/ac_motor_pwm_gen.sv | 96 +++++++++
 tb/tb_ac_motor_pwm_gen.sv | 127 ++++++++++++
 2 files changed

// File: rtl/ac_motor_pwm_gen.sv
// ac_motor_pwm_gen: three-phase center-aligned PWM against a shared up/down carrier with double-buffered updates.
// Define AC_MOTOR_PWM_DOUBLE_UPDATE_EN to add a second update point at the carrier peak.
module ac_motor_pwm_gen #(
   parameter int WIDTH = 11
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             ENABLE,
   input  logic [WIDTH-1:0] PERIOD,
   input  logic [WIDTH-1:0] DUTY_U,
   input  logic [WIDTH-1:0] DUTY_V,
   input  logic [WIDTH-1:0] DUTY_W,
   input  logic             LOAD,
   output logic             S_U,
   output logic             S_V,
   output logic             S_W,
   output logic [WIDTH-1:0] CARRIER,
   output logic             SYNC,
   output logic             LOAD_ACK
);
   localparam logic [WIDTH-1:0] P_MIN = WIDTH'(2);
   logic [WIDTH-1:0] cnt, cnt_n, p_in, p_src, p_nxt;
   logic [WIDTH-1:0] p_act, du_act, dv_act, dw_act;
   logic [WIDTH-1:0] p_stg, du_stg, dv_stg, dw_stg;
   logic             dir_up, dir_n, pending, upd, take;
   assign CARRIER = cnt;
   assign p_in    = PERIOD < P_MIN ? P_MIN : PERIOD;
   assign p_src   = LOAD ? p_in : p_stg;
   assign take    = ENABLE && upd && (LOAD || pending);
   assign p_nxt   = take ? p_src : p_act;
`ifdef AC_MOTOR_PWM_DOUBLE_UPDATE_EN
   // the peak is the first cycle of the down slope, so a new period restarts the descent from it
   assign upd   = dir_up ? cnt == '0 : cnt == p_act;
   assign cnt_n = dir_up ? cnt + 1'b1 : (cnt == p_act ? p_nxt - 1'b1 : cnt - 1'b1);
`else
   assign upd   = dir_up && cnt == '0;
   assign cnt_n = dir_up ? cnt + 1'b1 : cnt - 1'b1;
`endif
   assign dir_n = cnt_n == '0 ? 1'b1 : (cnt_n >= p_nxt ? 1'b0 : dir_up);
   always_ff @(posedge CLK) begin
      if (RESET) begin
         cnt      <= '0;
         dir_up   <= 1'b1;
         p_act    <= P_MIN;
         du_act   <= '0;
         dv_act   <= '0;
         dw_act   <= '0;
         p_stg    <= '0;
         du_stg   <= '0;
         dv_stg   <= '0;
         dw_stg   <= '0;
         pending  <= 1'b0;
         S_U      <= 1'b0;
         S_V      <= 1'b0;
         S_W      <= 1'b0;
         SYNC     <= 1'b0;
         LOAD_ACK <= 1'b0;
      end else begin
         if (LOAD) begin
            p_stg  <= p_in;
            du_stg <= DUTY_U;
            dv_stg <= DUTY_V;
            dw_stg <= DUTY_W;
         end
         if (!ENABLE) begin
            cnt      <= '0;
            dir_up   <= 1'b1;
            p_act    <= p_in;
            du_act   <= DUTY_U;
            dv_act   <= DUTY_V;
            dw_act   <= DUTY_W;
            pending  <= 1'b0;
            S_U      <= 1'b0;
            S_V      <= 1'b0;
            S_W      <= 1'b0;
            SYNC     <= 1'b0;
            LOAD_ACK <= 1'b0;
         end else begin
            cnt      <= cnt_n;
            dir_up   <= dir_n;
            SYNC     <= cnt_n == '0;
            S_U      <= cnt < du_act;
            S_V      <= cnt < dv_act;
            S_W      <= cnt < dw_act;
            LOAD_ACK <= take;
            pending  <= upd ? 1'b0 : pending | LOAD;
            if (take) begin
               p_act  <= p_nxt;
               du_act <= LOAD ? DUTY_U : du_stg;
               dv_act <= LOAD ? DUTY_V : dv_stg;
               dw_act <= LOAD ? DUTY_W : dw_stg;
            end
         end
      end
   end
endmodule

// File: tb/tb_ac_motor_pwm_gen.sv
// tb_ac_motor_pwm_gen: directed checks of carrier shape, duty compare, staged loads, enable and reset.
module tb_ac_motor_pwm_gen;
   logic        CLK = 1'b0, RESET = 1'b1, ENABLE = 1'b0, LOAD = 1'b0;
   logic [10:0] PERIOD = '0, DUTY_U = '0, DUTY_V = '0, DUTY_W = '0;
   logic        S_U, S_V, S_W, SYNC, LOAD_ACK;
   logic [10:0] CARRIER;
   int          n_chk = 0, n_pass = 0;

   ac_motor_pwm_gen dut (
      .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .PERIOD(PERIOD),
      .DUTY_U(DUTY_U), .DUTY_V(DUTY_V), .DUTY_W(DUTY_W), .LOAD(LOAD),
      .S_U(S_U), .S_V(S_V), .S_W(S_W), .CARRIER(CARRIER), .SYNC(SYNC), .LOAD_ACK(LOAD_ACK)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
   endtask

   task automatic cyc(input int c, input int a, input int su);
      @(posedge CLK); #1;
      check("carrier", int'(CARRIER), c);
      check("sync", int'(SYNC), int'(c == 0));
      check("load_ack", int'(LOAD_ACK), a);
      check("s_u", int'(S_U), su);
   endtask

   task automatic wait_ack(input int lim);
      bit seen = 0;
      for (int i = 0; i < lim && !seen; i++) begin
         @(posedge CLK); #1;
         LOAD = 1'b0;
         seen = LOAD_ACK;
      end
      check("ack_seen", int'(seen), 1);
   endtask

   task automatic idle_check(input string tag);
      check({tag, "_carrier"}, int'(CARRIER), 0);
      check({tag, "_s_u"}, int'(S_U), 0);
      check({tag, "_s_w"}, int'(S_W), 0);
      check({tag, "_sync"}, int'(SYNC), 0);
      check({tag, "_ack"}, int'(LOAD_ACK), 0);
   endtask

   initial begin
      int c1[11] = '{1, 2, 3, 4, 3, 2, 1, 0, 1, 2, 3};
      int s1[11] = '{0, 1, 0, 0, 0, 0, 0, 1, 1, 1, 0};
      int highs;
      @(posedge CLK); #1;
      idle_check("reset");
      // P=4, D=2/0/9 loaded on the very first update point (bypass)
      RESET = 1'b0; ENABLE = 1'b1; LOAD = 1'b1;
      PERIOD = 11'd4; DUTY_U = 11'd2; DUTY_V = 11'd0; DUTY_W = 11'd9;
      for (int i = 0; i < 11; i++) begin
         cyc(c1[i], int'(i == 0), s1[i]);
         LOAD = 1'b0;
         if (i > 0) begin
            check("s_v_zero", int'(S_V), 0);
            check("s_w_one", int'(S_W), 1);
         end
      end
      // P=10 staged mid-period, effective only after the valley
      PERIOD = 11'd10; LOAD = 1'b1;
      cyc(4, 0, 0);
      LOAD = 1'b0;
      cyc(3, 0, 0); cyc(2, 0, 0); cyc(1, 0, 0); cyc(0, 0, 1);
      cyc(1, 1, 1); cyc(2, 0, 1); cyc(3, 0, 0);
      for (int c = 4; c <= 10; c++) cyc(c, 0, 0);
      cyc(9, 0, 0);
      // two loads in one period: the later one wins
      DUTY_U = 11'd1; LOAD = 1'b1;
      cyc(8, 0, 0);
      LOAD = 1'b0;
      cyc(7, 0, 0);
      DUTY_U = 11'd3; LOAD = 1'b1;
      cyc(6, 0, 0);
      LOAD = 1'b0;
      for (int c = 5; c >= 1; c--) cyc(c, 0, 0);
      cyc(0, 0, 1); cyc(1, 1, 1);
      highs = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge CLK); #1;
         highs += int'(S_U);
      end
      check("d3_high_cycles", highs, 5);
      check("d3_end_carrier", int'(CARRIER), 1);
      // PERIOD 0 and 1 clamp to a peak of 2
      PERIOD = 11'd0; LOAD = 1'b1;
      wait_ack(40);
      check("p0_carrier", int'(CARRIER), 1);
      cyc(2, 0, 1); cyc(1, 0, 1); cyc(0, 0, 1); cyc(1, 0, 1); cyc(2, 0, 1);
      PERIOD = 11'd1; LOAD = 1'b1;
      wait_ack(40);
      check("p1_carrier", int'(CARRIER), 1);
      cyc(2, 0, 1); cyc(1, 0, 1); cyc(0, 0, 1); cyc(1, 0, 1); cyc(2, 0, 1);
      // ENABLE dropped mid-period, then resumed with tracked inputs
      PERIOD = 11'd10; LOAD = 1'b1;
      wait_ack(40);
      cyc(2, 0, 1); cyc(3, 0, 1); cyc(4, 0, 0); cyc(5, 0, 0);
      ENABLE = 1'b0; DUTY_U = 11'd4; PERIOD = 11'd6;
      @(posedge CLK); #1;
      idle_check("disabled");
      @(posedge CLK); #1;
      ENABLE = 1'b1;
      cyc(1, 0, 1); cyc(2, 0, 1); cyc(3, 0, 1); cyc(4, 0, 1);
      cyc(5, 0, 0); cyc(6, 0, 0); cyc(5, 0, 0);
      check("resume_s_w", int'(S_W), 1);
      // reset at CARRIER=7 with LOAD asserted
      PERIOD = 11'd10; LOAD = 1'b1;
      wait_ack(40);
      repeat (6) @(posedge CLK);
      #1;
      check("pre_reset_carrier", int'(CARRIER), 7);
      RESET = 1'b1; LOAD = 1'b1; PERIOD = 11'd3; DUTY_U = 11'd1;
      @(posedge CLK); #1;
      idle_check("mid_reset");
      RESET = 1'b0; LOAD = 1'b0;
      cyc(1, 0, 0); cyc(2, 0, 0); cyc(1, 0, 0); cyc(0, 0, 0);
      check("post_reset_s_w", int'(S_W), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
